// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one combinational-read, sync-write memory.
// Define ARB_PERF_CNT_EN to add the conflict_cnt / wait_cnt performance counters.
module mem_port_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned AW       = 16,
   parameter int unsigned DW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_valid,
   input  logic [AW-1:0] if_addr,
   output logic          if_ready,
   output logic          if_rsp_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_valid,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ready,
   output logic          d_rsp_valid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
`ifdef ARB_PERF_CNT_EN
   output logic [15:0]   conflict_cnt,
   output logic [15:0]   wait_cnt,
`endif
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e        r_state;
   logic          r_owner_d;
   logic [7:0]    r_starve;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_mem_we;
   logic          r_if_rsp_valid;
   logic          r_d_rsp_valid;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          w_d_ready;
   logic          w_if_ready;

   // Data wins unless IF has been refused MAX_WAIT times in a row.
   always_comb begin
      w_d_ready  = 1'b0;
      w_if_ready = 1'b0;
      if (r_state == StIdle) begin
         w_d_ready  = d_valid & ~(if_valid & (r_starve == MaxWait));
         w_if_ready = if_valid & ~w_d_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= StIdle;
         r_owner_d      <= 1'b0;
         r_starve       <= '0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_mem_we       <= 1'b0;
         r_if_rsp_valid <= 1'b0;
         r_d_rsp_valid  <= 1'b0;
         r_if_rdata     <= '0;
         r_d_rdata      <= '0;
      end else begin
         r_if_rsp_valid <= 1'b0;
         r_d_rsp_valid  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_if_ready) begin
                  r_starve <= '0;
               end else if (if_valid && r_starve != MaxWait) begin
                  r_starve <= r_starve + 8'd1;
               end
               if (w_d_ready) begin
                  r_owner_d   <= 1'b1;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
                  r_mem_we    <= d_we;
                  r_state     <= StAccess;
               end else if (w_if_ready) begin
                  r_owner_d  <= 1'b0;
                  r_mem_addr <= if_addr;
                  r_mem_we   <= 1'b0;
                  r_state    <= StAccess;
               end
            end
            StAccess: begin
               // r_mem_we doubles as the latched store flag for a data access.
               if (r_owner_d) begin
                  r_d_rsp_valid <= 1'b1;
                  if (!r_mem_we) r_d_rdata <= mem_rdata;
               end else begin
                  r_if_rsp_valid <= 1'b1;
                  r_if_rdata     <= mem_rdata;
               end
               r_mem_we <= 1'b0;
               r_state  <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign if_ready     = w_if_ready;
   assign d_ready      = w_d_ready;
   assign if_rsp_valid = r_if_rsp_valid;
   assign d_rsp_valid  = r_d_rsp_valid;
   assign if_rdata     = r_if_rdata;
   assign d_rdata      = r_d_rdata;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_we       = r_mem_we;

`ifdef ARB_PERF_CNT_EN
   logic [15:0] r_conflict_cnt;
   logic [15:0] r_wait_cnt;

   // wait_cnt includes ACCESS cycles: IF is refused whenever it is valid but not ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_conflict_cnt <= '0;
         r_wait_cnt     <= '0;
      end else begin
         if (r_state == StIdle && if_valid && d_valid && r_conflict_cnt != 16'hFFFF)
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         if (if_valid && !w_if_ready && r_wait_cnt != 16'hFFFF)
            r_wait_cnt <= r_wait_cnt + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
   assign wait_cnt     = r_wait_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int MaxWait = 4;

   logic        clk;
   logic        rst;
   logic        if_valid;
   logic [15:0] if_addr;
   logic        if_ready;
   logic        if_rsp_valid;
   logic [15:0] if_rdata;
   logic        d_valid;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ready;
   logic        d_rsp_valid;
   logic [15:0] d_rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [15:0] conflict_cnt;
   logic [15:0] wait_cnt;
`endif

   mem_port_arbiter #(
      .MAX_WAIT (MaxWait),
      .AW       (16),
      .DW       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_addr      (if_addr),
      .if_ready     (if_ready),
      .if_rsp_valid (if_rsp_valid),
      .if_rdata     (if_rdata),
      .d_valid      (d_valid),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ready      (d_ready),
      .d_rsp_valid  (d_rsp_valid),
      .d_rdata      (d_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
`ifdef ARB_PERF_CNT_EN
      .conflict_cnt (conflict_cnt),
      .wait_cnt     (wait_cnt),
`endif
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: halfword storage, addresses kept even and below 0x200.
   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   logic        preload;

   function automatic logic [15:0] init_val(input int i);
      return (i == 8) ? 16'h1234 : 16'((i * 40503) ^ 23130);
   endfunction

   assign mem_rdata = mem[mem_addr[8:1]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (mem_we) begin
         mem[mem_addr[8:1]] <= mem_wdata;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model state: one access in flight at most, responses one edge after it.
   bit          m_busy, m_own_d, m_we;
   logic [15:0] m_addr, m_wdata;
   int          m_starve;
   bit          exp_if_rsp, exp_d_rsp;
   logic [15:0] exp_if_rdata, exp_d_rdata;
   int          m_conf, m_wait;
   bit          last_d_xfer, last_if_xfer;
   logic        obs_d_rdy, obs_if_rdy, obs_if_rsp, obs_mem_we;
   logic [15:0] obs_if_rdata, obs_d_rdata, obs_mem_addr, obs_mem_wdata;

   task automatic model_reset();
      m_busy = 0; m_own_d = 0; m_we = 0; m_starve = 0;
      exp_if_rsp = 0; exp_d_rsp = 0; exp_if_rdata = '0; exp_d_rdata = '0;
      m_conf = 0; m_wait = 0; last_d_xfer = 0; last_if_xfer = 0;
   endtask

   // Called just after a rising edge; checks at the falling edge, then advances the model.
   task automatic cycle();
      bit edr, eir, emwe;
      @(negedge clk);
      edr  = !m_busy && d_valid && !(if_valid && m_starve >= MaxWait);
      eir  = !m_busy && if_valid && !edr;
      emwe = m_busy && m_own_d && m_we;
      check("d_ready", d_ready, edr);
      check("if_ready", if_ready, eir);
      check("if_rsp_valid", if_rsp_valid, exp_if_rsp);
      check("d_rsp_valid", d_rsp_valid, exp_d_rsp);
      check("if_rdata", if_rdata, exp_if_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      check("mem_we", mem_we, emwe);
      if (m_busy) check("mem_addr", mem_addr, m_addr);
      if (emwe) check("mem_wdata", mem_wdata, m_wdata);
`ifdef ARB_PERF_CNT_EN
      check("conflict_cnt", conflict_cnt, m_conf);
      check("wait_cnt", wait_cnt, m_wait);
      if (!m_busy && if_valid && d_valid && m_conf < 65535) m_conf++;
      if (if_valid && !eir && m_wait < 65535) m_wait++;
`endif
      obs_d_rdy = d_ready; obs_if_rdy = if_ready; obs_if_rsp = if_rsp_valid;
      obs_if_rdata = if_rdata; obs_d_rdata = d_rdata; obs_mem_we = mem_we;
      obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata;
      exp_if_rsp = 0;
      exp_d_rsp  = 0;
      if (m_busy) begin
         if (m_own_d) begin
            exp_d_rsp = 1;
            if (m_we) ref_mem[m_addr[8:1]] = m_wdata;
            else exp_d_rdata = ref_mem[m_addr[8:1]];
         end else begin
            exp_if_rsp   = 1;
            exp_if_rdata = ref_mem[m_addr[8:1]];
         end
         m_busy = 0;
      end else begin
         if (eir) m_starve = 0;
         else if (if_valid && m_starve < MaxWait) m_starve++;
         if (edr) begin
            m_busy = 1; m_own_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
         end else if (eir) begin
            m_busy = 1; m_own_d = 0; m_we = 0; m_addr = if_addr;
         end
      end
      last_d_xfer  = edr;
      last_if_xfer = eir;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] raddr();
      return 16'($urandom_range(0, 255)) << 1;
   endfunction

   int grant_idx;
   int n_rsp;
   int n_we;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      model_reset();
      rst = 1'b1; preload = 1'b1;
      if_valid = 0; if_addr = '0; d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      preload = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 16'h0000);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_if_rdata", if_rdata, 16'h0000);
      cycle();

      // IF fetch of the preloaded halfword.
      if_valid = 1; if_addr = 16'h0010;
      cycle();
      check("t1_if_ready", obs_if_rdy, 1'b1);
      if_valid = 0;
      cycle();
      cycle();
      check("t1_rsp", obs_if_rsp, 1'b1);
      check("t1_rdata", obs_if_rdata, 16'h1234);
      cycle();

      // Store then load at 0x0020.
      n_we = 0;
      d_valid = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
      cycle(); n_we += int'(obs_mem_we);
      d_valid = 0;
      cycle(); n_we += int'(obs_mem_we);
      check("t2_we", obs_mem_we, 1'b1);
      check("t2_addr", obs_mem_addr, 16'h0020);
      check("t2_wdata", obs_mem_wdata, 16'hBEEF);
      cycle(); n_we += int'(obs_mem_we);
      check("t2_store_rdata", obs_d_rdata, 16'h0000);
      d_valid = 1; d_we = 0; d_wdata = 16'h0000;
      cycle(); n_we += int'(obs_mem_we);
      d_valid = 0;
      cycle(); n_we += int'(obs_mem_we);
      cycle(); n_we += int'(obs_mem_we);
      check("t2_load_rdata", obs_d_rdata, 16'hBEEF);
      check("t2_we_cycles", n_we, 1);

      // Sustained contention: D,D,D,D,IF repeating.
      grant_idx = 0;
      if_valid = 1; if_addr = 16'h0040; d_valid = 1; d_we = 0; d_addr = 16'h0060;
      for (int c = 0; c < 30; c++) begin
         cycle();
         check("arb_both_ready", obs_d_rdy & obs_if_rdy, 1'b0);
         if (obs_d_rdy | obs_if_rdy) begin
            check("arb_seq", obs_if_rdy, (grant_idx % 5) == 4);
            grant_idx++;
         end
         d_addr = raddr();
      end

      // Back-to-back IF: accepted in the same cycle as the previous response.
      d_valid = 0; n_rsp = 0;
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (obs_if_rsp) begin
            n_rsp++;
            check("b2b_accept", obs_if_rdy, 1'b1);
         end
      end
      check("b2b_count", n_rsp >= 9, 1'b1);

      // Reset during a store ACCESS.
      if_valid = 0;
      cycle();
      cycle();
      d_valid = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'hCAFE;
      cycle();
      d_valid = 0;
      #2;
      check("rst_pre_we", mem_we, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_we_drop", mem_we, 1'b0);
      check("rst_d_rsp", d_rsp_valid, 1'b0);
      check("rst_if_rsp", if_rsp_valid, 1'b0);
      check("rst_d_rdata", d_rdata, 16'h0000);
      check("rst_if_rdata2", if_rdata, 16'h0000);
      check("rst_addr2", mem_addr, 16'h0000);
      check("rst_wdata2", mem_wdata, 16'h0000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_no_write", mem[24], ref_mem[24]);
      check("rst_d_rsp_after", d_rsp_valid, 1'b0);

      // Randomized traffic with requesters that hold until accepted.
      for (int c = 0; c < 400; c++) begin
         if (!if_valid || last_if_xfer) begin
            if_valid = ($urandom_range(0, 2) != 0);
            if_addr  = raddr();
         end else if ($urandom_range(0, 7) == 0) begin
            if_addr = raddr();
         end
         if (!d_valid || last_d_xfer) begin
            d_valid = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) != 0;
            d_addr  = raddr();
            d_wdata = 16'($urandom);
         end else if ($urandom_range(0, 7) == 0) begin
            d_addr  = raddr();
            d_wdata = 16'($urandom);
         end
         cycle();
      end
      if_valid = 0; d_valid = 0;
      repeat (3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
